btn_debounce: RTL

//  Input conditioning stage directly upstream of the safe-cracking FSM. It debounces N_BTN raw

---
 rtl/btn_pkg.sv | 11 +
 rtl/btn_debounce_ch.sv | 94 +++++++++
 rtl/btn_debounce.sv | 71 +++++++
 3 files changed

// File: rtl/btn_pkg.sv
// Shared types and helpers for the pushbutton debouncer.
package btn_pkg;

  typedef enum logic {STABLE = 1'b0, CHECK = 1'b1} db_state_t;

  // Number of clk cycles a new level must persist before it is accepted.
  function automatic int db_cycles(input int clk_hz, input int ms);
    return clk_hz / 1000 * ms;
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One debounce channel: synchroniser, stability counter, STABLE/CHECK FSM and
// registered press/release pulses aligned with the debounced level change.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int SYNC_STAGES = 2
) (
  input  logic      clk,
  input  logic      rstn,
  input  logic      btn_raw_i,
  output logic      btn_db_o,
  output logic      press_o,
  output logic      release_o,
  output db_state_t state_o
);

  localparam int DB_CYCLES = db_cycles(CLK_HZ, DEBOUNCE_MS);
  localparam int CW        = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s;
  db_state_t              state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   db_q, db_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], btn_raw_i};
  assign s      = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    db_d      = db_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      STABLE: begin
        cnt_d = '0;
        if (s != db_q) begin
          state_d = CHECK;
          cnt_d   = CNT_ONE;
        end
      end
      CHECK: begin
        if (s == db_q) begin
          // Any bounce back to the current level restarts the qualification.
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d   = STABLE;
          cnt_d     = '0;
          db_d      = ~db_q;
          press_d   = db_q;
          release_d = ~db_q;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q    <= '1;
      state_q   <= STABLE;
      cnt_q     <= '0;
      db_q      <= 1'b1;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      db_q      <= db_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign btn_db_o  = db_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign state_o   = state_q;

endmodule

// File: rtl/btn_debounce.sv
// N_BTN-channel active-low pushbutton debouncer feeding the safe-cracking FSM.
// Optional BTN_CHORD_REJECT_EN adds the chord output and multi-button press suppression.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int N_BTN       = 3,
  parameter int CLK_HZ      = 50_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_db,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
`ifdef BTN_CHORD_REJECT_EN
  output logic             chord,
`endif
  output logic [N_BTN-1:0] dbg_state_o
);

  logic [N_BTN-1:0] ch_press;

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    db_state_t ch_state;

    btn_debounce_ch #(
      .CLK_HZ     (CLK_HZ),
      .DEBOUNCE_MS(DEBOUNCE_MS),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_ch (
      .clk      (clk),
      .rstn     (rstn),
      .btn_raw_i(btn_raw[g]),
      .btn_db_o (btn_db[g]),
      .press_o  (ch_press[g]),
      .release_o(btn_release[g]),
      .state_o  (ch_state)
    );

    assign dbg_state_o[g] = ch_state;
  end

`ifdef BTN_CHORD_REJECT_EN
  logic [N_BTN-1:0] held;
  logic             chord_q, chord_d;

  assign held = ~btn_db;
  // x & (x-1) clears the lowest set bit, so non-zero means two or more held.
  assign chord_d = |(held & (held - N_BTN'(1)));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) chord_q <= 1'b0;
    else       chord_q <= chord_d;
  end

  assign chord = chord_q;

  // A channel that just went low is already in held, so simultaneous presses cancel too.
  always_comb begin
    btn_press = '0;
    for (int i = 0; i < N_BTN; i++) begin
      btn_press[i] = ch_press[i] & ~|(held & ~(N_BTN'(1) << i));
    end
  end
`else
  assign btn_press = ch_press;
`endif

endmodule
